load_wb_unit: RTL and testbench
===============================

LOAD_WB_UNIT -- requirements
Module: load_wb_unit

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 5, register index width; DATA_WIDTH, default 32, data width.
REQ-002 SHALL have ports as listed:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- req_valid  input  1  writeback request offered.
- req_ready  output  1  unit can accept a request this cycle.
- req_is_load  input  1  1 = load, 0 = plain result writeback.
- req_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- req_rd  input  ADDR_WIDTH  destination register index.
- req_data  input  DATA_WIDTH  result to write (non-load) or byte address (load).
- mem_req_valid  output  1  memory read request.
- mem_req_ready  input  1  memory accepts the request.
- mem_req_addr  output  32  word-aligned read address.
- mem_resp_valid  input  1  read data valid.
- mem_resp_data  input  32  read word.
- rf_wen  output  1  register-file write enable.
- rf_waddr  output  ADDR_WIDTH  register-file write index.
- rf_wdata  output  DATA_WIDTH  register-file write data.
- load_err  output  1  one-cycle pulse: misaligned or illegal load.
- busy  output  1  state is not IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, MREQ, MWAIT, WB, ERR.
REQ-004 SHALL drive req_ready=1 only in IDLE; a handshake is req_valid & req_ready.
REQ-005 SHALL register req_rd, req_funct3, and req_data at handshake.
REQ-006 Handshake with req_is_load=0 SHALL go IDLE->WB and hold req_data as the write value.
REQ-007 Handshake with a legal, aligned load SHALL go IDLE->MREQ.
- LB/LBU: any address.
- LH/LHU: addr[0]=0.
- LW: addr[1:0]=00.
REQ-008 A misaligned load or reserved funct3 (011, 110, 111) SHALL go IDLE->ERR, issue no memory request, and perform no register write.
REQ-009 In MREQ, the unit SHALL:
- assert mem_req_valid with mem_req_addr = {addr[31:2], 2'b00};
- hold both stable until mem_req_ready;
- on mem_req_valid & mem_req_ready, go to MWAIT.
REQ-010 In MWAIT, the unit SHALL:
- wait indefinitely for mem_resp_valid;
- on mem_resp_valid, capture the extracted value and go to WB.
REQ-011 Extraction SHALL be shifted = mem_resp_data >> (8*addr[1:0]), then:
- LB: sign-extend shifted[7:0];
- LBU: zero-extend shifted[7:0];
- LH: sign-extend shifted[15:0];
- LHU: zero-extend shifted[15:0];
- LW: use mem_resp_data unchanged.
REQ-012 In WB (exactly one cycle), the unit SHALL:
- drive rf_waddr = rd and rf_wdata = the captured value;
- drive rf_wen = 1 only if rd != 0;
- then go WB->IDLE.
REQ-013 In ERR (exactly one cycle), the unit SHALL assert load_err=1, then go ERR->IDLE.
REQ-014 rf_wen, mem_req_valid, and load_err SHALL be 0 in every state other than their own.
REQ-015 mem_resp_valid outside MWAIT and mem_req_ready outside MREQ SHALL be ignored.
REQ-016 Latency from handshake to rf_wen SHALL be:
- non-load: 1 cycle;
- load: 3 cycles minimum (zero-wait memory), plus one cycle per mem_req_ready stall and per mem_resp_valid wait cycle.
REQ-017 busy SHALL equal (state != IDLE); the next request SHALL be accepted in the cycle after WB or ERR.

Reset
REQ-018 rst_n low SHALL asynchronously force:
- state IDLE;
- all captured registers to 0;
- rf_wen=0, mem_req_valid=0, load_err=0, busy=0, req_ready=1 (combinational from IDLE).
REQ-019 Reset asserted mid-operation (MREQ or MWAIT) SHALL abandon the transaction with no register write; a late mem_resp_valid after release SHALL be ignored.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Non-load: rd=5, data=0xDEADBEEF -> next cycle rf_wen=1, waddr=5, wdata=0xDEADBEEF; then req_ready=1.
- LB: addr=0x80000003, resp=0x80FF1234, zero-wait memory -> mem_req_addr=0x80000000; rf_wdata=0xFFFFFF80 three cycles after handshake.
- LHU: addr=0x80000002, resp=0x8001ABCD, two mem_req_ready stall cycles and one response wait -> rf_wdata=0x00008001 with latency 6.
- LW misaligned: addr=0x80000001 -> mem_req_valid never asserted; load_err one-cycle pulse next cycle; rf_wen stays 0.
- LW: rd=0, resp=0x12345678 -> full memory handshake; rf_wen stays 0.
- Reset in MWAIT, then mem_resp_valid=1 after release -> state IDLE, no rf_wen, req_ready=1.

Source files
------------

// File: rtl/load_wb_unit.sv
// load_wb_unit: writeback stage for a simple in-order core.
// A plain result goes straight to the register file. A load first passes
// the alignment checks, then issues a word-aligned memory read and writes
// back the byte, half or word it extracts from the response.
module load_wb_unit #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_is_load,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_rd,
   input  logic [DATA_WIDTH-1:0] req_data,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [31:0]           mem_req_addr,
   input  logic                  mem_resp_valid,
   input  logic [31:0]           mem_resp_data,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic                  load_err,
   output logic                  busy
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      MREQ  = 3'd1,
      MWAIT = 3'd2,
      WB    = 3'd3,
      ERR   = 3'd4
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_rd;
   logic [2:0]            r_funct3;
   // Holds the load address until the response arrives, then the value to write.
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_rfWen;
   logic                  r_memReqValid;
   logic                  r_loadErr;

   logic                  w_handshake;
   logic                  w_legalLoad;
   logic [15:0]           w_half;
   logic [DATA_WIDTH-1:0] w_loadValue;

   assign req_ready     = (r_state == IDLE);
   assign w_handshake   = req_valid & req_ready;
   assign busy          = (r_state != IDLE);
   assign mem_req_valid = r_memReqValid;
   assign mem_req_addr  = 32'(r_data) & 32'hFFFF_FFFC;
   assign rf_wen        = r_rfWen;
   assign rf_waddr      = r_rd;
   assign rf_wdata      = r_data;
   assign load_err      = r_loadErr;

   // Decide whether the offered load has a known funct3 and a naturally aligned address.
   always_comb begin
      w_legalLoad = 1'b0;
      case (req_funct3)
         3'b000, 3'b100: w_legalLoad = 1'b1;
         3'b001, 3'b101: w_legalLoad = ~req_data[0];
         3'b010:         w_legalLoad = (req_data[1:0] == 2'b00);
         default:        w_legalLoad = 1'b0;
      endcase
   end

   // Shift the addressed byte/half down to bit 0 and extend it to the register width.
   always_comb begin
      w_half      = 16'(mem_resp_data >> {r_data[1:0], 3'b000});
      w_loadValue = DATA_WIDTH'(mem_resp_data);
      case (r_funct3)
         3'b000:  w_loadValue = {{(DATA_WIDTH-8){w_half[7]}}, w_half[7:0]};
         3'b100:  w_loadValue = DATA_WIDTH'(w_half[7:0]);
         3'b001:  w_loadValue = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
         3'b101:  w_loadValue = DATA_WIDTH'(w_half);
         default: w_loadValue = DATA_WIDTH'(mem_resp_data);
      endcase
   end

   // Main FSM: captures the request, runs the memory handshake and produces the registered strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_rd          <= '0;
         r_funct3      <= '0;
         r_data        <= '0;
         r_rfWen       <= 1'b0;
         r_memReqValid <= 1'b0;
         r_loadErr     <= 1'b0;
      end else begin
         r_rfWen   <= 1'b0;
         r_loadErr <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_handshake) begin
                  r_rd     <= req_rd;
                  r_funct3 <= req_funct3;
                  r_data   <= req_data;
                  if (!req_is_load) begin
                     r_state <= WB;
                     r_rfWen <= (req_rd != '0);
                  end else if (w_legalLoad) begin
                     r_state       <= MREQ;
                     r_memReqValid <= 1'b1;
                  end else begin
                     r_state   <= ERR;
                     r_loadErr <= 1'b1;
                  end
               end
            end
            MREQ: begin
               if (mem_req_ready) begin
                  r_state       <= MWAIT;
                  r_memReqValid <= 1'b0;
               end
            end
            MWAIT: begin
               if (mem_resp_valid) begin
                  r_state <= WB;
                  r_data  <= w_loadValue;
                  r_rfWen <= (r_rd != '0);
               end
            end
            WB: begin
               r_state <= IDLE;
            end
            ERR: begin
               r_state <= IDLE;
            end
            default: begin
               r_state       <= IDLE;
               r_memReqValid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_wb_unit.sv
// tb_load_wb_unit: directed and randomized checks of load_wb_unit against
// a transaction-level reference model kept in the bench.
module tb_load_wb_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_load;
   logic [2:0]  req_funct3;
   logic [4:0]  req_rd;
   logic [31:0] req_data;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        load_err;
   logic        busy;

   int testCount = 0;
   int failCount = 0;
   bit checkEn   = 1'b0;

   load_wb_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_is_load    (req_is_load),
      .req_funct3     (req_funct3),
      .req_rd         (req_rd),
      .req_data       (req_data),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .rf_wen         (rf_wen),
      .rf_waddr       (rf_waddr),
      .rf_wdata       (rf_wdata),
      .load_err       (load_err),
      .busy           (busy)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something never returns.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference legality rule: byte loads anywhere, halves on even addresses, words on multiples of 4.
   function automatic bit modelLegal(input logic [2:0] f3, input logic [31:0] addr);
      int unsigned a;
      a = addr;
      case (f3)
         3'd0, 3'd4: return 1'b1;
         3'd1, 3'd5: return (a % 2) == 0;
         3'd2:       return (a % 4) == 0;
         default:    return 1'b0;
      endcase
   endfunction

   // Reference extraction: pick bytes out of the word by little-endian offset and extend arithmetically.
   function automatic logic [31:0] modelExtract(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
      int off;
      int bytes [4];
      int byteVal;
      int halfVal;
      off = int'(addr % 4);
      for (int i = 0; i < 4; i++) bytes[i] = int'((word >> (8 * i)) & 32'hFF);
      byteVal = bytes[off];
      halfVal = byteVal;
      if (off < 3) halfVal = byteVal + 256 * bytes[off + 1];
      case (f3)
         3'd0:    return (byteVal >= 128) ? 32'(byteVal - 256) : 32'(byteVal);
         3'd4:    return 32'(byteVal);
         3'd1:    return (halfVal >= 32768) ? 32'(halfVal - 65536) : 32'(halfVal);
         3'd5:    return 32'(halfVal);
         default: return word;
      endcase
   endfunction

   // Model of the outstanding work: which handshake or strobe is pending, and the transaction data.
   logic        mReqOut;
   logic        mRespOut;
   logic        mWrite;
   logic        mErr;
   logic [4:0]  mRd;
   logic [2:0]  mF3;
   logic [31:0] mAddr;
   logic [31:0] mValue;
   logic        expIdle;

   assign expIdle = !(mReqOut || mRespOut || mWrite || mErr);

   // Advance the model on each edge from the inputs the unit sees.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mReqOut  <= 1'b0;
         mRespOut <= 1'b0;
         mWrite   <= 1'b0;
         mErr     <= 1'b0;
         mRd      <= '0;
         mF3      <= '0;
         mAddr    <= '0;
         mValue   <= '0;
      end else begin
         mWrite <= 1'b0;
         mErr   <= 1'b0;
         if (expIdle && req_valid) begin
            mRd   <= req_rd;
            mAddr <= req_data;
            mF3   <= req_funct3;
            if (!req_is_load) begin
               mWrite <= 1'b1;
               mValue <= req_data;
            end else if (modelLegal(req_funct3, req_data)) begin
               mReqOut <= 1'b1;
            end else begin
               mErr <= 1'b1;
            end
         end
         if (mReqOut && mem_req_ready) begin
            mReqOut  <= 1'b0;
            mRespOut <= 1'b1;
         end
         if (mRespOut && mem_resp_valid) begin
            mRespOut <= 1'b0;
            mWrite   <= 1'b1;
            mValue   <= modelExtract(mF3, mAddr, mem_resp_data);
         end
      end
   end

   // Compare every output against the model on the falling edge.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("req_ready", 32'(req_ready), 32'(expIdle));
         checkOutput("busy", 32'(busy), 32'(!expIdle));
         checkOutput("mem_req_valid", 32'(mem_req_valid), 32'(mReqOut));
         checkOutput("load_err", 32'(load_err), 32'(mErr));
         checkOutput("rf_wen", 32'(rf_wen), 32'(mWrite && (mRd != 5'd0)));
         if (mReqOut) checkOutput("mem_req_addr", mem_req_addr, mAddr & 32'hFFFF_FFFC);
         if (mWrite) begin
            checkOutput("rf_waddr", 32'(rf_waddr), 32'(mRd));
            checkOutput("rf_wdata", rf_wdata, mValue);
         end
      end
   end

   // Drive one cycle's inputs, then let one rising edge pass and settle just after it.
   task automatic applyStimulus(input logic valid, input logic isLoad, input logic [2:0] f3,
                                input logic [4:0] rd, input logic [31:0] data, input logic memReady,
                                input logic respValid, input logic [31:0] respData);
      req_valid      = valid;
      req_is_load    = isLoad;
      req_funct3     = f3;
      req_rd         = rd;
      req_data       = data;
      mem_req_ready  = memReady;
      mem_resp_valid = respValid;
      mem_resp_data  = respData;
      @(posedge clk);
      #1;
   endtask

   // One load with a scripted number of request stalls and response waits; records what was seen.
   task automatic runLoad(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                          input logic [31:0] word, input int stalls, input int waits,
                          output int lat, output bit sawReq, output logic [31:0] seenAddr,
                          output logic [31:0] seenData, output int errCount, output int errEdge,
                          output int wenCount);
      lat = 0; sawReq = 1'b0; seenAddr = '0; seenData = '0;
      errCount = 0; errEdge = 0; wenCount = 0;
      for (int i = 0; i < 4 + stalls + waits; i++) begin
         applyStimulus(i == 0, 1'b1, f3, rd, addr, i == 1 + stalls, i == 2 + stalls + waits, word);
         if (rf_wen) begin
            wenCount++;
            if (lat == 0) lat = i + 1;
            seenData = rf_wdata;
         end
         if (mem_req_valid) begin
            sawReq   = 1'b1;
            seenAddr = mem_req_addr;
         end
         if (load_err) begin
            errCount++;
            if (errEdge == 0) errEdge = i + 1;
         end
      end
   endtask

   initial begin
      int lat;
      bit sawReq;
      logic [31:0] seenAddr;
      logic [31:0] seenData;
      int errCount;
      int errEdge;
      int wenCount;
      logic [31:0] rndAddr;

      rst_n = 1'b0;
      req_valid = 1'b0; req_is_load = 1'b0; req_funct3 = '0; req_rd = '0; req_data = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
      repeat (3) @(posedge clk);
      #1;

      checkOutput("reset req_ready", 32'(req_ready), 32'd1);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset rf_wen", 32'(rf_wen), 32'd0);
      checkOutput("reset mem_req_valid", 32'(mem_req_valid), 32'd0);
      checkOutput("reset load_err", 32'(load_err), 32'd0);

      checkOutput("model LB pin", modelExtract(3'd0, 32'h8000_0003, 32'h80FF_1234), 32'hFFFF_FF80);
      checkOutput("model LHU pin", modelExtract(3'd5, 32'h8000_0002, 32'h8001_ABCD), 32'h0000_8001);
      checkOutput("model LH pin", modelExtract(3'd1, 32'h8000_0002, 32'h8001_ABCD), 32'hFFFF_8001);
      checkOutput("model LW align pin", 32'(modelLegal(3'd2, 32'h8000_0001)), 32'd0);

      rst_n = 1'b1;
      checkEn = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

      // Non-load writeback.
      applyStimulus(1, 0, 3'd0, 5'd5, 32'hDEAD_BEEF, 0, 0, 0);
      checkOutput("nonload rf_wen", 32'(rf_wen), 32'd1);
      checkOutput("nonload waddr", 32'(rf_waddr), 32'd5);
      checkOutput("nonload wdata", rf_wdata, 32'hDEAD_BEEF);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("nonload ready after", 32'(req_ready), 32'd1);
      checkOutput("nonload wen cleared", 32'(rf_wen), 32'd0);

      // LB, zero-wait memory.
      runLoad(3'd0, 5'd3, 32'h8000_0003, 32'h80FF_1234, 0, 0, lat, sawReq, seenAddr, seenData, errCount, errEdge, wenCount);
      checkOutput("LB mem_req_addr", seenAddr, 32'h8000_0000);
      checkOutput("LB latency", 32'(lat), 32'd3);
      checkOutput("LB wdata", seenData, 32'hFFFF_FF80);
      checkOutput("LB wen count", 32'(wenCount), 32'd1);

      // LHU with two request stalls and one response wait.
      runLoad(3'd5, 5'd9, 32'h8000_0002, 32'h8001_ABCD, 2, 1, lat, sawReq, seenAddr, seenData, errCount, errEdge, wenCount);
      checkOutput("LHU mem_req_addr", seenAddr, 32'h8000_0000);
      checkOutput("LHU latency", 32'(lat), 32'd6);
      checkOutput("LHU wdata", seenData, 32'h0000_8001);

      // Misaligned LW.
      runLoad(3'd2, 5'd4, 32'h8000_0001, 32'h1111_2222, 0, 0, lat, sawReq, seenAddr, seenData, errCount, errEdge, wenCount);
      checkOutput("LWmis no mem req", 32'(sawReq), 32'd0);
      checkOutput("LWmis err edge", 32'(errEdge), 32'd1);
      checkOutput("LWmis err pulses", 32'(errCount), 32'd1);
      checkOutput("LWmis wen count", 32'(wenCount), 32'd0);

      // LW to x0: full memory handshake, no register write.
      runLoad(3'd2, 5'd0, 32'h0000_0040, 32'h1234_5678, 0, 0, lat, sawReq, seenAddr, seenData, errCount, errEdge, wenCount);
      checkOutput("LWx0 mem req seen", 32'(sawReq), 32'd1);
      checkOutput("LWx0 mem_req_addr", seenAddr, 32'h0000_0040);
      checkOutput("LWx0 wen count", 32'(wenCount), 32'd0);
      checkOutput("LWx0 ready after", 32'(req_ready), 32'd1);

      // Reset while waiting for the response, then a late response.
      applyStimulus(1, 1, 3'd2, 5'd7, 32'h8000_0010, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
      checkOutput("rstMW busy before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #2;
      checkOutput("rstMW busy in reset", 32'(busy), 32'd0);
      checkOutput("rstMW ready in reset", 32'(req_ready), 32'd1);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D);
         checkOutput("rstMW late resp wen", 32'(rf_wen), 32'd0);
         checkOutput("rstMW late resp ready", 32'(req_ready), 32'd1);
         checkOutput("rstMW late resp busy", 32'(busy), 32'd0);
      end

      // Randomized traffic with occasional asynchronous resets.
      for (int n = 0; n < 4000; n++) begin
         rndAddr = $urandom;
         if ($urandom_range(1) == 0) rndAddr[1:0] = 2'b00;
         req_valid      = ($urandom_range(2) != 0);
         req_is_load    = ($urandom_range(3) != 0);
         req_funct3     = 3'($urandom_range(7));
         req_rd         = 5'($urandom_range(31));
         req_data       = rndAddr;
         mem_req_ready  = ($urandom_range(1) != 0);
         mem_resp_valid = ($urandom_range(4) < 2);
         mem_resp_data  = $urandom;
         if ($urandom_range(199) == 0) begin
            rst_n = 1'b0;
            #2;
            rst_n = 1'b1;
         end
         @(posedge clk);
         #1;
      end

      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkEn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
